// File: rtl/router_pkg.sv
// Shared types and constants for the router egress scheduler: FSM states,
// header field positions and the beat record carried through the skid buffer.
package router_pkg;

  localparam int unsigned NUM_PORTS            = 3;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 30;

  localparam int unsigned HDR_ADDR_LSB = 0;
  localparam int unsigned HDR_ADDR_MSB = 1;
  localparam int unsigned HDR_LEN_LSB  = 2;
  localparam int unsigned HDR_LEN_MSB  = 7;

  typedef enum logic [2:0] {
    IDLE,
    HDR_RD,
    HDR_WAIT,
    BODY,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] port;
  } beat_t;

  function automatic logic [1:0] port_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic vld_sel(input logic [NUM_PORTS-1:0] v, input logic [1:0] p);
    case (p)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Three-entry beat FIFO between the router read port and the downstream stream.
// Occupancy and head entry come straight from registers.
module router_skid_buf
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output beat_t      head,
  output logic       head_valid,
  output logic [1:0] occupancy
);

  beat_t      mem [3];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [1:0] count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= port_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= port_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head       = mem[rd_ptr];
  assign head_valid = (count != 2'd0);
  assign occupancy  = count;

endmodule

// File: rtl/router_egress_sched.sv
// Egress scheduler: drains whole packets from the three router FIFOs round-robin
// onto one byte stream with SOP/EOP, parity check and starvation flags.
module router_egress_sched
  import router_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int unsigned BUF_DEPTH    = 3
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 vld_out_0,
  input  logic                 vld_out_1,
  input  logic                 vld_out_2,
  input  logic [7:0]           data_out_0,
  input  logic [7:0]           data_out_1,
  input  logic [7:0]           data_out_2,
  output logic                 read_enb_0,
  output logic                 read_enb_1,
  output logic                 read_enb_2,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [1:0]           out_port,
  output logic                 out_perr,
  output logic [NUM_PORTS-1:0] starve
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  state_t               state, state_nx;
  logic [1:0]           grant, grant_nx;
  logic [1:0]           rr, rr_nx;
  logic [1:0]           pick, cand;
  logic                 pick_found;
  logic [6:0]           remaining, remaining_nx;
  logic                 rd_en, rd_sop, rd_eop;
  logic                 infl_valid, infl_sop, infl_eop;
  logic [1:0]           infl_port;
  logic [7:0]           rx_data;
  logic [7:0]           parity;
  logic [5:0]           hdr_len;
  logic [NUM_PORTS-1:0] vld_vec;
  logic [NUM_PORTS-1:0] granted;
  logic                 grant_vld, credit_ok, pop;
  beat_t                head, push_beat;
  logic                 head_valid;
  logic [1:0]           occupancy;

  assign vld_vec   = {vld_out_2, vld_out_1, vld_out_0};
  assign grant_vld = vld_sel(vld_vec, grant);
  assign hdr_len   = rx_data[HDR_LEN_MSB:HDR_LEN_LSB];
  assign credit_ok = ({1'b0, occupancy} + {2'b00, infl_valid}) <= 3'(BUF_DEPTH - 1);
  assign pop       = head_valid && out_ready;

  always_comb begin
    case (infl_port)
      2'd0:    rx_data = data_out_0;
      2'd1:    rx_data = data_out_1;
      default: rx_data = data_out_2;
    endcase
  end

  always_comb begin
    pick       = rr;
    pick_found = 1'b0;
    cand       = rr;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!pick_found && vld_sel(vld_vec, cand)) begin
        pick       = cand;
        pick_found = 1'b1;
      end
      cand = port_inc(cand);
    end
  end

  always_comb begin
    state_nx     = state;
    grant_nx     = grant;
    rr_nx        = rr;
    remaining_nx = remaining;
    rd_en        = 1'b0;
    rd_sop       = 1'b0;
    rd_eop       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nx = pick;
          state_nx = HDR_RD;
        end
      end
      HDR_RD: begin
        rd_en    = 1'b1;
        rd_sop   = 1'b1;
        state_nx = HDR_WAIT;
      end
      HDR_WAIT: begin
        // Every packet has at least a parity byte after the header, so the first
        // body read can go out while the header lands; keeps SOP-to-EOP gapless.
        remaining_nx = {1'b0, hdr_len} + 7'd1;
        if (grant_vld && credit_ok) begin
          rd_en        = 1'b1;
          rd_eop       = (hdr_len == 6'd0);
          remaining_nx = {1'b0, hdr_len};
        end
        state_nx = (remaining_nx == 7'd0) ? DRAIN : BODY;
      end
      BODY: begin
        if ((remaining != 7'd0) && grant_vld && credit_ok) begin
          rd_en        = 1'b1;
          rd_eop       = (remaining == 7'd1);
          remaining_nx = remaining - 7'd1;
          if (remaining == 7'd1) begin
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && head.eop) begin
          rr_nx    = port_inc(grant);
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= '0;
      rr         <= '0;
      remaining  <= '0;
      infl_valid <= 1'b0;
      infl_sop   <= 1'b0;
      infl_eop   <= 1'b0;
      infl_port  <= '0;
      parity     <= '0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      rr         <= rr_nx;
      remaining  <= remaining_nx;
      infl_valid <= rd_en;
      infl_sop   <= rd_sop;
      infl_eop   <= rd_eop;
      infl_port  <= grant;
      if (pop) begin
        parity <= head.eop ? 8'h00 : (parity ^ head.data);
      end
    end
  end

  assign push_beat = '{data: rx_data, sop: infl_sop, eop: infl_eop, port: infl_port};

  router_skid_buf u_buf (
    .clock      (clock),
    .resetn     (resetn),
    .push       (infl_valid),
    .push_beat  (push_beat),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .occupancy  (occupancy)
  );

  assign read_enb_0 = rd_en && (grant == 2'd0);
  assign read_enb_1 = rd_en && (grant == 2'd1);
  assign read_enb_2 = rd_en && (grant == 2'd2);

  assign out_valid = head_valid;
  assign out_data  = head.data;
  assign out_sop   = head_valid && head.sop;
  assign out_eop   = head_valid && head.eop;
  assign out_port  = head.port;
  assign out_perr  = head_valid && head.eop && (parity != head.data);

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_starve
    logic [CNT_W-1:0] wait_cnt;
    logic             pulse;

    assign granted[k] = (state != IDLE) && (grant == 2'(k));

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        wait_cnt <= '0;
        pulse    <= 1'b0;
      end else if (!vld_vec[k] || granted[k]) begin
        wait_cnt <= '0;
        pulse    <= 1'b0;
      end else if (wait_cnt != CNT_W'(STARVE_LIMIT)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
        pulse    <= (wait_cnt == CNT_W'(STARVE_LIMIT - 1));
      end else begin
        pulse <= 1'b0;
      end
    end

    assign starve[k] = pulse;
  end

endmodule

// File: tb/tb_router_egress_sched.sv
// Bench for router_egress_sched: behavioural router FIFOs, scoreboard of
// expected stream bytes, packet vector table and hand-written corner sequences.
module tb_router_egress_sched;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic [7:0] data_out_0 = '0, data_out_1 = '0, data_out_2 = '0;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_sop, out_eop, out_perr;
  logic [1:0] out_port;
  logic [2:0] starve;

  router_egress_sched #(.STARVE_LIMIT(30), .BUF_DEPTH(3)) dut (
    .clock(clock), .resetn(resetn),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_port(out_port),
    .out_perr(out_perr), .starve(starve)
  );

  always #5 clock = ~clock;

  // Router FIFO model: fmem/wr_n written by the stimulus, rd_n by the read process.
  logic [7:0]  fmem [3][1024];
  int unsigned wr_n [3];
  int unsigned rd_n [3];
  int unsigned overread = 0;
  logic [2:0]  hold = '0;

  assign vld_out_0 = (wr_n[0] != rd_n[0]) && !hold[0];
  assign vld_out_1 = (wr_n[1] != rd_n[1]) && !hold[1];
  assign vld_out_2 = (wr_n[2] != rd_n[2]) && !hold[2];

  always @(posedge clock) begin
    if (read_enb_0) begin
      data_out_0 <= fmem[0][rd_n[0] % 1024];
      rd_n[0]    <= rd_n[0] + 1;
      if (rd_n[0] == wr_n[0]) overread = overread + 1;
    end
    if (read_enb_1) begin
      data_out_1 <= fmem[1][rd_n[1] % 1024];
      rd_n[1]    <= rd_n[1] + 1;
      if (rd_n[1] == wr_n[1]) overread = overread + 1;
    end
    if (read_enb_2) begin
      data_out_2 <= fmem[2][rd_n[2] % 1024];
      rd_n[2]    <= rd_n[2] + 1;
      if (rd_n[2] == wr_n[2]) overread = overread + 1;
    end
  end

  int unsigned ready_mode = 0;
  always begin
    @(posedge clock);
    #1;
    out_ready = (ready_mode == 0) ? 1'b1 : ~out_ready;
  end

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] port;
    logic       perr;
  } exp_t;

  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          sop_cyc = 0;
  int          last_span = -1;
  logic        prev_stall = 1'b0;
  logic [13:0] prev_snap = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // One clock: advance to the negedge, then check stall stability and pop the scoreboard.
  task automatic tick();
    exp_t        e;
    logic [12:0] act;
    @(negedge clock);
    cyc++;
    if (!resetn) begin
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      chk("hold_stable", {out_valid, out_data, out_sop, out_eop, out_port, out_perr}, prev_snap);
    end
    if (out_valid && out_ready) begin
      act = {out_data, out_sop, out_eop, out_port, out_perr};
      if (sb.size() == 0) begin
        chk("unexpected_byte", act, 13'h0000);
        chk("unexpected_byte_count", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("stream_byte {data,sop,eop,port,perr}", act, e);
      end
      if (out_sop) sop_cyc = cyc;
      if (out_eop) last_span = cyc - sop_cyc;
    end
    prev_stall = out_valid && !out_ready;
    prev_snap  = {out_valid, out_data, out_sop, out_eop, out_port, out_perr};
  endtask

  task automatic load_pkt(input int unsigned p, input logic [7:0] hdr, input logic corrupt);
    int unsigned len;
    logic [7:0]  par, b;
    len = int'(hdr[7:2]);
    par = hdr;
    fmem[p][wr_n[p] % 1024] = hdr;
    sb.push_back({hdr, 1'b1, 1'b0, 2'(p), 1'b0});
    for (int unsigned i = 1; i <= len; i++) begin
      b   = 8'(i * 37 + p * 11 + hdr);
      par = par ^ b;
      fmem[p][(wr_n[p] + i) % 1024] = b;
      sb.push_back({b, 1'b0, 1'b0, 2'(p), 1'b0});
    end
    b = par ^ {7'b0, corrupt};
    fmem[p][(wr_n[p] + len + 1) % 1024] = b;
    sb.push_back({b, 1'b0, 1'b1, 2'(p), corrupt});
    wr_n[p] = wr_n[p] + len + 2;
  endtask

  task automatic wait_done(input string name, input int unsigned budget);
    int unsigned n;
    n = 0;
    while ((sb.size() != 0) && (n < budget)) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d bytes outstanding required 0", name, sb.size());
      sb.delete();
    end
    repeat (3) tick();
  endtask

  typedef struct {
    int unsigned port;
    logic [7:0]  hdr;
    logic        corrupt;
    int unsigned exp_reads;
    int          exp_span;
  } vec_t;

  vec_t        vecs [5];
  int unsigned r0;
  int unsigned cnt_a, cnt_b, cnt_c, first_n;

  initial begin
    vecs[0] = '{0, 8'h00, 1'b0,  2,  1};
    vecs[1] = '{1, 8'h05, 1'b1,  3,  2};
    vecs[2] = '{0, 8'h40, 1'b1, 18, 17};
    vecs[3] = '{2, 8'hFE, 1'b0, 65, 64};
    vecs[4] = '{2, 8'h16, 1'b0,  7,  6};
    for (int i = 0; i < 3; i++) begin
      wr_n[i] = 0;
      rd_n[i] = 0;
    end

    #1 resetn = 1'b0;
    #2;
    chk("reset_outputs", {read_enb_0, read_enb_1, read_enb_2, out_valid, out_sop, out_eop,
                          out_perr, out_port, out_data, starve}, '0);
    repeat (3) tick();
    resetn = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) begin
      r0 = rd_n[vecs[i].port];
      load_pkt(vecs[i].port, vecs[i].hdr, vecs[i].corrupt);
      wait_done("vec", 200);
      chk("vec_reads", rd_n[vecs[i].port] - r0, vecs[i].exp_reads);
      chk("vec_span", last_span, vecs[i].exp_span);
    end

    // All three ports valid at once from pointer 0: order 0,1,2, then pointer back at 0.
    load_pkt(0, 8'h40, 1'b0);
    load_pkt(1, 8'h39, 1'b0);
    load_pkt(2, 8'h16, 1'b0);
    wait_done("rr_three", 300);
    load_pkt(0, 8'h00, 1'b0);
    load_pkt(2, 8'h00, 1'b0);
    wait_done("rr_wrap", 50);

    // Downstream stalls every other cycle on a len-14 packet.
    ready_mode = 1;
    r0 = rd_n[1];
    load_pkt(1, 8'h39, 1'b0);
    wait_done("toggle", 200);
    chk("toggle_reads", rd_n[1] - r0, 16);
    ready_mode = 0;
    repeat (2) tick();

    // vld_out drops mid-packet: reads pause, no other port is granted meanwhile.
    load_pkt(0, 8'h20, 1'b0);
    load_pkt(1, 8'h08, 1'b0);
    repeat (5) tick();
    hold[0] = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (read_enb_0) cnt_a++;
      if (read_enb_1 || read_enb_2) cnt_b++;
    end
    hold[0] = 1'b0;
    chk("pause_reads_granted", cnt_a, 0);
    chk("pause_reads_other", cnt_b, 0);
    wait_done("pause", 200);

    // Port 1 waits behind a len-63 packet on port 0.
    load_pkt(0, 8'hFC, 1'b0);
    repeat (3) tick();
    load_pkt(1, 8'h00, 1'b0);
    cnt_a   = 0;
    cnt_b   = 0;
    first_n = 0;
    for (int unsigned n = 1; n <= 120; n++) begin
      tick();
      if (starve[1]) begin
        cnt_a++;
        if (first_n == 0) first_n = n;
      end
      if (starve[0] || starve[2]) cnt_b++;
    end
    chk("starve1_pulses", cnt_a, 1);
    chk("starve1_cycle", first_n, 30);
    chk("starve_other_pulses", cnt_b, 0);
    wait_done("starve", 200);

    // Asynchronous reset in the middle of a packet body.
    load_pkt(0, 8'h50, 1'b0);
    load_pkt(1, 8'h0C, 1'b0);
    repeat (6) tick();
    chk("pre_reset_busy", out_valid, 1);
    #2 resetn = 1'b0;
    #1;
    chk("midpkt_reset_outputs", {read_enb_0, read_enb_1, read_enb_2, out_valid, out_sop, out_eop,
                                 out_perr, out_port, out_data, starve}, '0);
    sb.delete();
    for (int i = 0; i < 3; i++) wr_n[i] = rd_n[i];
    repeat (2) tick();
    resetn = 1'b1;
    repeat (2) tick();
    load_pkt(1, 8'h00, 1'b0);
    load_pkt(2, 8'h04, 1'b0);
    wait_done("post_reset", 50);

    chk("fifo_overread", overread, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
